// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// fetch_stage : MIPS IF stage - PC register, next-PC select, IF/ID register,
//               saturating stall/redirect event counters.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pc_stall,
   input  logic             IF_ID_stall,
   input  logic             branch_taken,
   input  logic [31:0]      branch_target,
   input  logic             jump,
   input  logic [31:0]      jump_target,
   input  logic [31:0]      imem_instr,
   input  logic             cnt_clr,
   output logic [31:0]      imem_addr,
   output logic [31:0]      IF_ID_instr,
   output logic [31:0]      IF_ID_pc_plus4,
   output logic             IF_ID_valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] redirect_cnt
);

   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [31:0]      C_PC_RST  = {RESET_PC[31:2], 2'b00};

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      pc4_q, pc4_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

   logic [31:0]      w_pc_plus4;
   logic             w_redirect;

   // A redirect seen while the PC is stalled is dropped; ID re-presents it.
   always_comb begin
      w_pc_plus4 = pc_q + 32'd4;
      w_redirect = (branch_taken | jump) & ~pc_stall;

      pc_d = pc_q;
      if (!pc_stall) begin
         if (jump)              pc_d = {jump_target[31:2], 2'b00};
         else if (branch_taken) pc_d = {branch_target[31:2], 2'b00};
         else                   pc_d = w_pc_plus4;
      end

      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (!IF_ID_stall) begin
         pc4_d = w_pc_plus4;
         if (w_redirect) begin
            instr_d = 32'h0000_0000;
            valid_d = 1'b0;
         end else begin
            instr_d = imem_instr;
            valid_d = 1'b1;
         end
      end
   end

   // Clear wins over increment; counters stick at all-ones.
   always_comb begin
      stall_cnt_d    = stall_cnt_q;
      redirect_cnt_d = redirect_cnt_q;
      if (cnt_clr) begin
         stall_cnt_d    = '0;
         redirect_cnt_d = '0;
      end else begin
         if (pc_stall && (stall_cnt_q != C_CNT_MAX))
            stall_cnt_d = stall_cnt_q + 1'b1;
         if (w_redirect && (redirect_cnt_q != C_CNT_MAX))
            redirect_cnt_d = redirect_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q           <= C_PC_RST;
         instr_q        <= '0;
         pc4_q          <= '0;
         valid_q        <= 1'b0;
         stall_cnt_q    <= '0;
         redirect_cnt_q <= '0;
      end else begin
         pc_q           <= pc_d;
         instr_q        <= instr_d;
         pc4_q          <= pc4_d;
         valid_q        <= valid_d;
         stall_cnt_q    <= stall_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign imem_addr      = pc_q;
   assign IF_ID_instr    = instr_q;
   assign IF_ID_pc_plus4 = pc4_q;
   assign IF_ID_valid    = valid_q;
   assign stall_cnt      = stall_cnt_q;
   assign redirect_cnt   = redirect_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// tb_fetch_stage : directed + randomized bench for fetch_stage against a
//                  cycle-level behavioural model.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_stall, IF_ID_stall, branch_taken, jump, cnt_clr;
   logic [31:0] branch_target, jump_target;
   logic [31:0] imem_instr, imem_addr, IF_ID_instr, IF_ID_pc_plus4;
   logic        IF_ID_valid;
   logic [15:0] stall_cnt, redirect_cnt;

   logic [31:0] imem_instr_s, imem_addr_s, instr_s, pc4_s;
   logic        valid_s;
   logic [1:0]  stall_cnt_s, redirect_cnt_s;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   int          m_stall, m_red;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return 32'h2000_0000 | (a >> 2);
   endfunction

   assign imem_instr   = imem(imem_addr);
   assign imem_instr_s = imem(imem_addr_s);

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .imem_instr(imem_instr),
      .cnt_clr(cnt_clr), .imem_addr(imem_addr), .IF_ID_instr(IF_ID_instr),
      .IF_ID_pc_plus4(IF_ID_pc_plus4), .IF_ID_valid(IF_ID_valid),
      .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
   );

   fetch_stage #(.CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .imem_instr(imem_instr_s),
      .cnt_clr(cnt_clr), .imem_addr(imem_addr_s), .IF_ID_instr(instr_s),
      .IF_ID_pc_plus4(pc4_s), .IF_ID_valid(valid_s),
      .stall_cnt(stall_cnt_s), .redirect_cnt(redirect_cnt_s)
   );

   function automatic int sat(input int v, input int w);
      int mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic void model_reset();
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_stall = 0; m_red = 0;
   endfunction

   // Next state from the current inputs, then one clock edge.
   task automatic step();
      logic        redir;
      logic [31:0] seq;
      redir = (jump || branch_taken) && !pc_stall;
      seq   = m_pc + 32'd4;
      if (cnt_clr) begin
         m_stall = 0; m_red = 0;
      end else begin
         if (pc_stall) m_stall++;
         if (redir)    m_red++;
      end
      if (!IF_ID_stall) begin
         m_pc4   = seq;
         m_instr = redir ? 32'h0 : imem(m_pc);
         m_valid = !redir;
      end
      if (!pc_stall)
         m_pc = jump ? (jump_target & ~32'h3) :
                branch_taken ? (branch_target & ~32'h3) : seq;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pc_stall = 0; IF_ID_stall = 0; branch_taken = 0; jump = 0; cnt_clr = 0;
      branch_target = 32'h0; jump_target = 32'h0;
   endtask

   task automatic test_reset();
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", imem_addr); end
      checks++; if (IF_ID_instr !== 32'h0 || IF_ID_pc_plus4 !== 32'h0 || IF_ID_valid !== 1'b0) begin
         errors++; $display("FAIL reset_ifid: got %h/%h/%b exp 0/0/0", IF_ID_instr, IF_ID_pc_plus4, IF_ID_valid); end
      checks++; if (stall_cnt !== 16'h0 || redirect_cnt !== 16'h0) begin
         errors++; $display("FAIL reset_cnt: got %h/%h exp 0/0", stall_cnt, redirect_cnt); end
   endtask

   task automatic test_free_run();
      for (int i = 1; i <= 2; i++) begin
         step();
         checks++; if (imem_addr !== 32'(4*i)) begin errors++; $display("FAIL free_pc: got %h exp %h", imem_addr, 32'(4*i)); end
         checks++; if (IF_ID_pc_plus4 !== 32'(4*i) || IF_ID_valid !== 1'b1 || IF_ID_instr !== imem(32'(4*(i-1)))) begin
            errors++; $display("FAIL free_ifid: got %h/%b/%h exp %h/1/%h", IF_ID_pc_plus4, IF_ID_valid, IF_ID_instr, 32'(4*i), imem(32'(4*(i-1)))); end
      end
   endtask

   task automatic test_branch();
      branch_taken = 1; branch_target = 32'h0000_0102;
      step();
      idle_inputs();
      checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL branch_pc: got %h exp 100", imem_addr); end
      checks++; if (IF_ID_instr !== 32'h0 || IF_ID_valid !== 1'b0 || IF_ID_pc_plus4 !== 32'hC) begin
         errors++; $display("FAIL branch_bubble: got %h/%b/%h exp 0/0/c", IF_ID_instr, IF_ID_valid, IF_ID_pc_plus4); end
      checks++; if (redirect_cnt !== 16'd1) begin errors++; $display("FAIL branch_cnt: got %0d exp 1", redirect_cnt); end
      step();
      checks++; if (IF_ID_instr !== imem(32'h100) || IF_ID_valid !== 1'b1) begin
         errors++; $display("FAIL branch_target_instr: got %h/%b exp %h/1", IF_ID_instr, IF_ID_valid, imem(32'h100)); end
   endtask

   task automatic test_stall();
      logic [31:0] hold_pc, hold_instr;
      jump = 1; jump_target = 32'hC; step(); idle_inputs();
      hold_pc = imem_addr; hold_instr = IF_ID_instr;
      pc_stall = 1; IF_ID_stall = 1;
      repeat (2) step();
      idle_inputs();
      checks++; if (imem_addr !== 32'hC || hold_pc !== 32'hC) begin errors++; $display("FAIL stall_pc: got %h exp c", imem_addr); end
      checks++; if (IF_ID_instr !== hold_instr || IF_ID_valid !== 1'b0) begin
         errors++; $display("FAIL stall_ifid: got %h/%b exp %h/0", IF_ID_instr, IF_ID_valid, hold_instr); end
      checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt: got %0d exp 2", stall_cnt); end
      step();
      checks++; if (IF_ID_instr !== imem(32'hC) || imem_addr !== 32'h10) begin
         errors++; $display("FAIL stall_resume1: got %h/%h exp %h/10", IF_ID_instr, imem_addr, imem(32'hC)); end
      step();
      checks++; if (IF_ID_instr !== imem(32'h10) || IF_ID_pc_plus4 !== 32'h14) begin
         errors++; $display("FAIL stall_resume2: got %h/%h exp %h/14", IF_ID_instr, IF_ID_pc_plus4, imem(32'h10)); end
   endtask

   task automatic test_stall_jump();
      logic [15:0] r0;
      logic [31:0] p0;
      r0 = redirect_cnt; p0 = imem_addr;
      pc_stall = 1; IF_ID_stall = 1; jump = 1; jump_target = 32'h200;
      step();
      checks++; if (imem_addr !== p0 || redirect_cnt !== r0) begin
         errors++; $display("FAIL stall_jump_hold: got %h/%0d exp %h/%0d", imem_addr, redirect_cnt, p0, r0); end
      pc_stall = 0; IF_ID_stall = 0;
      step(); idle_inputs();
      checks++; if (imem_addr !== 32'h200 || redirect_cnt !== r0 + 16'd1) begin
         errors++; $display("FAIL stall_jump_go: got %h/%0d exp 200/%0d", imem_addr, redirect_cnt, r0 + 16'd1); end
   endtask

   task automatic test_priority_wrap();
      jump = 1; branch_taken = 1; jump_target = 32'h40; branch_target = 32'h80;
      step(); idle_inputs();
      checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL jump_priority: got %h exp 40", imem_addr); end
      jump = 1; jump_target = 32'hFFFF_FFFF;
      step(); idle_inputs();
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL align: got %h exp fffffffc", imem_addr); end
      step();
      checks++; if (imem_addr !== 32'h0 || IF_ID_pc_plus4 !== 32'h0 || IF_ID_instr !== imem(32'hFFFF_FFFC)) begin
         errors++; $display("FAIL wrap: got %h/%h/%h exp 0/0/%h", imem_addr, IF_ID_pc_plus4, IF_ID_instr, imem(32'hFFFF_FFFC)); end
   endtask

   task automatic test_saturation();
      cnt_clr = 1; step(); cnt_clr = 0;
      pc_stall = 1; IF_ID_stall = 1;
      repeat (5) step();
      checks++; if (stall_cnt_s !== 2'd3 || stall_cnt !== 16'd5) begin
         errors++; $display("FAIL sat: got %0d/%0d exp 3/5", stall_cnt_s, stall_cnt); end
      cnt_clr = 1;
      step();
      idle_inputs();
      checks++; if (stall_cnt_s !== 2'd0 || stall_cnt !== 16'd0) begin
         errors++; $display("FAIL clr_over_inc: got %0d/%0d exp 0/0", stall_cnt_s, stall_cnt); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         pc_stall      = ($urandom_range(0, 3) == 0);
         IF_ID_stall   = ($urandom_range(0, 7) == 0) ? ~pc_stall : pc_stall;
         jump          = ($urandom_range(0, 7) == 0);
         branch_taken  = ($urandom_range(0, 5) == 0);
         jump_target   = $urandom;
         branch_target = $urandom;
         cnt_clr       = ($urandom_range(0, 63) == 0);
         step();
         checks++;
         if (imem_addr !== m_pc || IF_ID_instr !== m_instr || IF_ID_pc_plus4 !== m_pc4 ||
             IF_ID_valid !== m_valid) begin
            errors++;
            $display("FAIL rand_state @%0d: got %h/%h/%h/%b exp %h/%h/%h/%b", i, imem_addr,
                     IF_ID_instr, IF_ID_pc_plus4, IF_ID_valid, m_pc, m_instr, m_pc4, m_valid);
         end
         checks++;
         if (stall_cnt !== 16'(sat(m_stall, 16)) || redirect_cnt !== 16'(sat(m_red, 16)) ||
             stall_cnt_s !== 2'(sat(m_stall, 2)) || redirect_cnt_s !== 2'(sat(m_red, 2))) begin
            errors++;
            $display("FAIL rand_cnt @%0d: got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", i, stall_cnt,
                     redirect_cnt, stall_cnt_s, redirect_cnt_s, sat(m_stall, 16), sat(m_red, 16),
                     sat(m_stall, 2), sat(m_red, 2));
         end
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      pc_stall = 1; IF_ID_stall = 1; jump = 1; jump_target = 32'h300;
      step();
      #2 rst_n = 0;
      #1;
      checks++; if (imem_addr !== 32'h0 || IF_ID_instr !== 32'h0 || IF_ID_pc_plus4 !== 32'h0 ||
                    IF_ID_valid !== 1'b0 || stall_cnt !== 16'h0 || redirect_cnt !== 16'h0) begin
         errors++; $display("FAIL async_reset: got %h/%h/%h/%b/%0d/%0d exp all 0", imem_addr,
                            IF_ID_instr, IF_ID_pc_plus4, IF_ID_valid, stall_cnt, redirect_cnt); end
      model_reset();
      idle_inputs();
      @(negedge clk);
      rst_n = 1;
      step();
      checks++; if (imem_addr !== 32'h4 || IF_ID_valid !== 1'b1 || IF_ID_instr !== imem(32'h0)) begin
         errors++; $display("FAIL post_reset: got %h/%b/%h exp 4/1/%h", imem_addr, IF_ID_valid, IF_ID_instr, imem(32'h0)); end
   endtask

   initial begin
      idle_inputs();
      rst_n = 0;
      model_reset();
      #2;
      test_reset();
      @(posedge clk);
      #1 rst_n = 1;
      test_free_run();
      test_branch();
      test_stall();
      test_stall_jump();
      test_priority_wrap();
      test_saturation();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
